// File: rtl/pe_pkg.sv
// Shared types and parameters for the PE arithmetic pipeline.
// Used by the issue controller, the PE wrapper and the NoC network interface.
package pe_pkg;

  localparam int PRECISION  = 32;
  localparam int MULT_LAT   = 10;
  localparam int SUB_LAT    = 25;
  localparam int TAG_W      = 6;
  localparam int OBUF_DEPTH = 32;
  localparam int CREDIT_W   = $clog2(OBUF_DEPTH + 1);

  typedef logic [PRECISION-1:0] word_t;
  typedef logic [TAG_W-1:0]     tag_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    tag_t  tag;
  } pe_req_t;

  typedef struct packed {
    word_t mult;
    word_t sub;
    tag_t  tag;
  } pe_rsp_t;

endpackage

// File: rtl/pe_issue_ctrl_if.sv
// Request, PE and result ports of the PE issue controller.
// The slave view belongs to the controller, the master view to its environment.
interface pe_issue_ctrl_if;
  import pe_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_a;
  word_t in_b;
  word_t in_c;
  tag_t  in_tag;

  word_t pe_a;
  word_t pe_b;
  word_t pe_c;
  word_t pe_mult_result;
  word_t pe_add_result;

  logic  out_valid;
  logic  out_ready;
  word_t out_mult;
  word_t out_sub;
  tag_t  out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_tag,
    input  pe_mult_result, pe_add_result,
    input  out_ready,
    output in_ready,
    output pe_a, pe_b, pe_c,
    output out_valid, out_mult, out_sub, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_tag,
    output pe_mult_result, pe_add_result,
    output out_ready,
    input  in_ready,
    input  pe_a, pe_b, pe_c,
    input  out_valid, out_mult, out_sub, out_tag
  );

endinterface

// File: rtl/pe_result_fifo.sv
// Show-ahead result buffer for the PE issue controller.
// Only pointers and count are reset; storage holds whatever was last written.
module pe_result_fifo
  import pe_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  pe_rsp_t pushData_i,
  input  logic    pop_i,
  output logic    valid_o,
  output pe_rsp_t head_o
);

  localparam int PTR_W = $clog2(OBUF_DEPTH);
  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

  pe_rsp_t          mem_q [OBUF_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, doPush, doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(OBUF_DEPTH));
  assign valid_o = (count_q != '0);
  assign doPush  = push_i & ~full;
  assign doPop   = pop_i & valid_o;
  // Gate the head so the result port reads zero whenever nothing is buffered
  assign head_o  = valid_o ? mem_q[rdPtr_q] : '0;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
      if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  pushWhileFull: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/pe_issue_ctrl.sv
// Credit-based issue controller for the fixed-latency PE (A*B, C-A*B).
// Realigns both PE results with their tag and buffers them for the consumer.
module pe_issue_ctrl
  import pe_pkg::*;
(
  input logic            clk,
  input logic            rst,
  pe_issue_ctrl_if.slave bus_io
);

  localparam int MDLY = SUB_LAT - MULT_LAT;

  pe_req_t             req;
  logic                inReady, issue, pop, push, fifoValid;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  word_t               peA_q, peB_q;
  word_t               cLine_q    [MULT_LAT+1];
  logic [SUB_LAT:0]    vldLine_q;
  tag_t                tagLine_q  [SUB_LAT+1];
  word_t               multLine_q [MDLY];
  pe_rsp_t             pushData, headData;

  assign req     = '{a: bus_io.in_a, b: bus_io.in_b, c: bus_io.in_c, tag: bus_io.in_tag};
  assign inReady = (credits_q != '0);
  assign issue   = bus_io.in_valid & inReady;
  assign pop     = fifoValid & bus_io.out_ready;
  assign push    = vldLine_q[SUB_LAT];

  // One credit per free buffer slot, so every issued request has room to land
  always_comb begin
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CREDIT_W'(1);
      2'b01:   credits_d = credits_q + CREDIT_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CREDIT_W'(OBUF_DEPTH);
      peA_q     <= '0;
      peB_q     <= '0;
      vldLine_q <= '0;
      for (int k = 0; k <= MULT_LAT; k++) cLine_q[k]    <= '0;
      for (int k = 0; k <= SUB_LAT; k++)  tagLine_q[k]  <= '0;
      for (int k = 0; k < MDLY; k++)      multLine_q[k] <= '0;
    end else begin
      credits_q    <= credits_d;
      peA_q        <= issue ? req.a : '0;
      peB_q        <= issue ? req.b : '0;
      // Index k of each line is aligned with the request that drove pe_a k cycles ago
      cLine_q[0]   <= issue ? req.c : '0;
      for (int k = 1; k <= MULT_LAT; k++) cLine_q[k] <= cLine_q[k-1];
      vldLine_q    <= {vldLine_q[SUB_LAT-1:0], issue};
      tagLine_q[0] <= issue ? req.tag : '0;
      for (int k = 1; k <= SUB_LAT; k++) tagLine_q[k] <= tagLine_q[k-1];
      // The product is only on the PE port for one cycle; hold it until the difference arrives
      multLine_q[0] <= vldLine_q[MULT_LAT] ? bus_io.pe_mult_result : '0;
      for (int k = 1; k < MDLY; k++) multLine_q[k] <= multLine_q[k-1];
    end
  end

  assign pushData = '{mult: multLine_q[MDLY-1], sub: bus_io.pe_add_result, tag: tagLine_q[SUB_LAT]};

  pe_result_fifo uResultFifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pushData_i (pushData),
    .pop_i      (pop),
    .valid_o    (fifoValid),
    .head_o     (headData)
  );

  assign bus_io.in_ready  = inReady;
  assign bus_io.pe_a      = peA_q;
  assign bus_io.pe_b      = peB_q;
  assign bus_io.pe_c      = cLine_q[MULT_LAT];
  assign bus_io.out_valid = fifoValid;
  assign bus_io.out_mult  = headData.mult;
  assign bus_io.out_sub   = headData.sub;
  assign bus_io.out_tag   = headData.tag;

endmodule
